// File: rtl/fetch_pc_unit_if.sv
// Fetch front-end bus bundle: redirect sources, instruction SRAM
// address/data handshake, and the decode-side valid/ready output.
interface fetch_pc_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              br_valid;
  logic [1:0]        br_mode;
  logic [ADDR_W-1:0] br_base;
  logic [ADDR_W-1:0] br_offset;
  logic              exc_valid;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [31:0]       out_inst;

  // Driver side: PC sources, SRAM responder, decode stage.
  modport master (
    output br_valid, br_mode, br_base, br_offset, exc_valid,
    output inst_addr_ok, inst_data_ok, inst_rdata, out_ready,
    input  inst_req, inst_addr, out_valid, out_pc, out_inst
  );

  // Fetch unit side.
  modport slave (
    input  br_valid, br_mode, br_base, br_offset, exc_valid,
    input  inst_addr_ok, inst_data_ok, inst_rdata, out_ready,
    output inst_req, inst_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: sequential PC generation with branch and
// exception redirect, pipelined SRAM requests, and an in-order
// {pc, inst} buffer feeding decode. Responses to requests issued before
// a redirect are counted in cancel_cnt and discarded on arrival.
module fetch_pc_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter logic [31:0] RESET_PC   = 32'hbfc00000,
  parameter logic [31:0] EXC_PC     = 32'hbfc00380,
  parameter int unsigned IBUF_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  fetch_pc_unit_if.slave bus
);
  localparam int unsigned PW = $clog2(IBUF_DEPTH);
  localparam int unsigned CW = $clog2(IBUF_DEPTH + 1);
  localparam logic [ADDR_W-1:0] RESET_PC_T = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_PC_T   = EXC_PC[ADDR_W-1:0];
  localparam logic [CW+1:0]     DEPTH_C    = (CW+2)'(IBUF_DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     cancel_q,   cancel_d;
  logic [CW-1:0]     count_q,    count_d;
  logic [PW-1:0]     pcq_wr_q,   pcq_wr_d;
  logic [PW-1:0]     pcq_rd_q,   pcq_rd_d;
  logic [PW-1:0]     head_q,     head_d;
  logic [PW-1:0]     tail_q,     tail_d;

  logic [ADDR_W-1:0] pcq_q      [IBUF_DEPTH];
  logic [ADDR_W-1:0] buf_pc_q   [IBUF_DEPTH];
  logic [31:0]       buf_inst_q [IBUF_DEPTH];

  logic              redir;
  logic [ADDR_W-1:0] target;
  logic [CW+1:0]     credit_sum;
  logic              req;
  logic              accept;
  logic              resp_live;
  logic              cancel_hit;
  logic              pop;

  assign bus.inst_req  = req;
  assign bus.inst_addr = fetch_pc_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_pc    = buf_pc_q[head_q];
  assign bus.out_inst  = buf_inst_q[head_q];

  // Redirect decode, credit check and handshake qualifiers.
  always_comb begin
    redir = bus.exc_valid | (bus.br_valid & (bus.br_mode != 2'b00));
    if (bus.exc_valid)
      target = EXC_PC_T;
    else if (bus.br_mode == 2'b01)
      target = bus.br_base + bus.br_offset;
    else
      target = bus.br_offset;
    target[1:0] = 2'b00;

    // Buffered + live + to-be-dropped responses never exceed the buffer.
    credit_sum = {2'b00, count_q} + {2'b00, inflight_q} + {2'b00, cancel_q};
    req        = ~rst & ~redir & (credit_sum < DEPTH_C);
    accept     = req & bus.inst_addr_ok;
    cancel_hit = bus.inst_data_ok & (cancel_q != '0);
    resp_live  = bus.inst_data_ok & (cancel_q == '0) & ~redir;
    pop        = bus.out_valid & bus.out_ready;
  end

  // Next-state for PC, in-flight bookkeeping and buffer pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    cancel_d   = cancel_q;
    count_d    = count_q;
    pcq_wr_d   = pcq_wr_q;
    pcq_rd_d   = pcq_rd_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (redir) begin
      // Every outstanding request becomes stale; a response arriving in
      // this same cycle retires one of them immediately.
      fetch_pc_d = target;
      cancel_d   = cancel_q + inflight_q - CW'(bus.inst_data_ok);
      inflight_d = '0;
      pcq_wr_d   = '0;
      pcq_rd_d   = '0;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        pcq_wr_d   = pcq_wr_q + PW'(1);
      end
      if (resp_live) begin
        pcq_rd_d = pcq_rd_q + PW'(1);
        tail_d   = tail_q + PW'(1);
      end
      if (pop)
        head_d = head_q + PW'(1);
      inflight_d = inflight_q + CW'(accept) - CW'(resp_live);
      cancel_d   = cancel_q - CW'(cancel_hit);
      count_d    = count_q + CW'(resp_live) - CW'(pop);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC_T;
      inflight_q <= '0;
      cancel_q   <= '0;
      count_q    <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      cancel_q   <= cancel_d;
      count_q    <= count_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // In-flight PC queue and instruction buffer storage (no reset needed).
  always_ff @(posedge clk) begin
    if (accept)
      pcq_q[pcq_wr_q] <= fetch_pc_q;
    if (resp_live) begin
      buf_pc_q[tail_q]   <= pcq_q[pcq_rd_q];
      buf_inst_q[tail_q] <= bus.inst_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic
// against a transaction-level model (outstanding SRAM requests tagged
// with a redirect epoch; only current-epoch responses reach decode).
module tb_fetch_pc_unit;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'hbfc00000;
  localparam logic [31:0] EXC_VEC = 32'hbfc00380;

  logic clk;
  logic rst_a, rst_b;

  fetch_pc_unit_if #(.ADDR_W(32)) ifa ();
  fetch_pc_unit_if #(.ADDR_W(16)) ifb ();

  fetch_pc_unit #(.ADDR_W(32), .RESET_PC(RST_PC), .EXC_PC(EXC_VEC), .IBUF_DEPTH(DEPTH))
    dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  fetch_pc_unit #(.ADDR_W(16), .RESET_PC(32'h0000fff8), .IBUF_DEPTH(DEPTH))
    dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int unsigned epoch; int unsigned ready; } sreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  sreq_t       sram_q[$];
  ent_t        mbuf[$];
  logic [31:0] model_pc;
  int unsigned epoch, cyc, acc_cnt;
  int unsigned rdy_pct, aok_pct, dok_pct, lat_min, lat_max;
  int unsigned n_checks, n_errors;
  bit          b_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579bdf;
  endfunction

  task automatic do_reset(input int unsigned n);
    rst_a = 1'b1;
    ifa.br_valid = 1'b0; ifa.exc_valid = 1'b0;
    ifa.inst_addr_ok = 1'b0; ifa.inst_data_ok = 1'b0; ifa.out_ready = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_inst_req", ifa.inst_req, 1'b0);
    chk("rst_out_valid", ifa.out_valid, 1'b0);
    sram_q.delete();
    mbuf.delete();
    model_pc = RST_PC;
    epoch++;
    rst_a = 1'b0;
  endtask

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic cycle(input bit f_br, input logic [1:0] f_mode, input logic [31:0] f_base,
                       input logic [31:0] f_off, input bit f_exc);
    bit redir, exp_req, acc, dok, pop;
    logic [31:0] tgt;
    sreq_t r;
    ifa.br_valid     = f_br;
    ifa.br_mode      = f_mode;
    ifa.br_base      = f_base;
    ifa.br_offset    = f_off;
    ifa.exc_valid    = f_exc;
    ifa.out_ready    = ($urandom_range(99) < rdy_pct);
    ifa.inst_addr_ok = ($urandom_range(99) < aok_pct);
    dok = (sram_q.size() != 0) && (sram_q[0].ready <= cyc) && ($urandom_range(99) < dok_pct);
    ifa.inst_data_ok = dok;
    ifa.inst_rdata   = dok ? mk_inst(sram_q[0].addr) : $urandom;
    #1;
    redir   = f_exc | (f_br & (f_mode != 2'b00));
    exp_req = !redir && (mbuf.size() + sram_q.size() < DEPTH);
    chk("inst_req", ifa.inst_req, exp_req);
    if (exp_req) chk("inst_addr", ifa.inst_addr, model_pc);
    chk("out_valid", ifa.out_valid, mbuf.size() != 0);
    if (ifa.out_valid && mbuf.size() != 0) begin
      chk("out_pc", ifa.out_pc, mbuf[0].pc);
      chk("out_inst", ifa.out_inst, mbuf[0].inst);
    end
    acc = ifa.inst_req & ifa.inst_addr_ok;
    pop = ifa.out_valid & ifa.out_ready;
    if (pop && mbuf.size() != 0) void'(mbuf.pop_front());
    if (dok) begin
      r = sram_q.pop_front();
      if (!redir && r.epoch == epoch) begin
        chk("buf_no_overflow", mbuf.size() < DEPTH, 1'b1);
        mbuf.push_back('{pc: r.addr, inst: mk_inst(r.addr)});
      end
    end
    if (acc) sram_q.push_back('{addr: ifa.inst_addr, epoch: epoch,
                                ready: cyc + $urandom_range(lat_max, lat_min)});
    if (redir) begin
      tgt = f_exc ? EXC_VEC : ((f_mode == 2'b01) ? f_base + f_off : f_off);
      tgt[1:0] = 2'b00;
      model_pc = tgt;
      mbuf.delete();
      epoch++;
    end else if (acc) begin
      model_pc = model_pc + 32'd4;
    end
    acc_cnt += acc;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 2'b00, '0, '0, 1'b0);
  endtask

  task automatic wait_valid(input int unsigned bound);
    for (int unsigned i = 0; i < bound && !ifa.out_valid; i++) idle(1);
  endtask

  task automatic set_knobs(input int unsigned r, input int unsigned a, input int unsigned d,
                           input int unsigned lmin, input int unsigned lmax);
    rdy_pct = r; aok_pct = a; dok_pct = d; lat_min = lmin; lat_max = lmax;
  endtask

  // Main DUT: directed scenarios then randomized traffic.
  initial begin
    int unsigned a0;
    n_checks = 0; n_errors = 0; epoch = 0; cyc = 0; acc_cnt = 0;
    ifa.br_mode = 2'b00; ifa.br_base = '0; ifa.br_offset = '0; ifa.inst_rdata = '0;
    @(negedge clk);
    set_knobs(100, 100, 100, 1, 1);
    do_reset(3);
    idle(12);

    // Backpressure: exactly DEPTH requests, then stall, then resume.
    do_reset(2);
    set_knobs(0, 100, 100, 1, 1);
    a0 = acc_cnt;
    idle(10);
    chk("bp_accepts", acc_cnt - a0, DEPTH);
    set_knobs(100, 100, 100, 1, 1);
    idle(10);

    // Relative branch with two requests in flight.
    do_reset(2);
    set_knobs(100, 100, 100, 5, 5);
    idle(2);
    cycle(1'b1, 2'b01, 32'hbfc00010, 32'h00000020, 1'b0);
    chk("br_rel_addr", ifa.inst_addr, 32'hbfc00030);
    wait_valid(30);
    chk("br_first_valid", ifa.out_valid, 1'b1);
    chk("br_first_pc", ifa.out_pc, 32'hbfc00030);

    // Exception beats branch; absolute target low bits forced to zero.
    cycle(1'b1, 2'b10, '0, 32'h80001000, 1'b1);
    chk("exc_addr", ifa.inst_addr, EXC_VEC);
    cycle(1'b1, 2'b11, '0, 32'h80001003, 1'b0);
    chk("br_abs_addr", ifa.inst_addr, 32'h80001000);
    idle(12);

    // Back-to-back redirects over three stale requests.
    do_reset(2);
    set_knobs(100, 100, 100, 4, 4);
    idle(3);
    cycle(1'b1, 2'b10, '0, 32'h00001000, 1'b0);
    idle(1);
    cycle(1'b1, 2'b10, '0, 32'h00002000, 1'b0);
    wait_valid(30);
    chk("b2b_valid", ifa.out_valid, 1'b1);
    chk("b2b_first_pc", ifa.out_pc, 32'h00002000);
    idle(8);

    // Randomized traffic with occasional mid-run reset.
    for (int unsigned blk = 0; blk < 15; blk++) begin
      set_knobs($urandom_range(100, 20), $urandom_range(100, 30), $urandom_range(100, 30),
                1, $urandom_range(6, 1));
      for (int unsigned i = 0; i < 200; i++) begin
        if ($urandom_range(999) < 3) do_reset(2);
        else cycle($urandom_range(99) < 5, 2'($urandom), $urandom, $urandom,
                   $urandom_range(99) < 2);
      end
    end

    for (int unsigned i = 0; i < 1000 && !b_done; i++) @(posedge clk);
    chk("wrap_done", b_done, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // 16-bit instance: address wrap with a one-cycle SRAM.
  initial begin
    logic [15:0] b_exp, b_pend_addr;
    bit          b_pend;
    logic [15:0] bq[$];
    b_done = 1'b0; b_pend = 1'b0; b_pend_addr = '0;
    rst_b = 1'b1;
    ifb.br_valid = 1'b0; ifb.br_mode = 2'b00; ifb.br_base = '0; ifb.br_offset = '0;
    ifb.exc_valid = 1'b0; ifb.inst_addr_ok = 1'b0; ifb.inst_data_ok = 1'b0;
    ifb.inst_rdata = '0; ifb.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    b_exp = 16'hfff8;
    for (int unsigned i = 0; i < 8; i++) begin
      ifb.inst_addr_ok = 1'b1;
      ifb.inst_data_ok = b_pend;
      ifb.inst_rdata   = {16'hc0de, b_pend_addr};
      #1;
      chk("w_req", ifb.inst_req, 1'b1);
      chk("w_addr", ifb.inst_addr, b_exp);
      chk("w_valid", ifb.out_valid, bq.size() != 0);
      if (bq.size() != 0) begin
        chk("w_out_pc", ifb.out_pc, bq[0]);
        chk("w_out_inst", ifb.out_inst, {16'hc0de, bq[0]});
        void'(bq.pop_front());
      end
      if (b_pend) bq.push_back(b_pend_addr);
      b_pend = 1'b1;
      b_pend_addr = b_exp;
      b_exp = b_exp + 16'd4;
      @(posedge clk);
      @(negedge clk);
    end
    ifb.inst_addr_ok = 1'b0;
    ifb.inst_data_ok = 1'b0;
    b_done = 1'b1;
  end
endmodule
